// File: rtl/mod_counter_if.sv
// Control and status bundle for the mod_counter block.
// The master drives the step/load controls and the slave reports the count and limit flags.
interface mod_counter_if #(
  parameter int WIDTH = 5
);
  logic             clear;
  logic             load;
  logic [WIDTH-1:0] load_val;
  logic             en;
  logic             dir;
  logic [WIDTH-1:0] max_in;
  logic [WIDTH-1:0] count;
  logic             at_max;
  logic             at_zero;
  logic             term;

  modport master (
    output clear, load, load_val, en, dir, max_in,
    input  count, at_max, at_zero, term
  );

  modport slave (
    input  clear, load, load_val, en, dir, max_in,
    output count, at_max, at_zero, term
  );
endinterface

// File: rtl/mod_counter.sv
// Up/down modulo counter with run-time modulus, parallel load, wrap/saturate limits
// and a registered one-cycle terminal pulse; used for grid stepping, scoring and prescaling.
module mod_counter #(
  parameter int WIDTH    = 5,
  parameter bit SATURATE = 1'b0
) (
  input logic        clk,
  input logic        rst,
  mod_counter_if.slave bus
);
  logic [WIDTH-1:0] count_q;
  logic             term_q;
  logic [WIDTH-1:0] load_clamped;

  assign load_clamped = (bus.load_val > bus.max_in) ? bus.max_in : bus.load_val;

  // Priority is clear > load > en > hold; term only rises on a limit event.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
      term_q  <= 1'b0;
    end else if (bus.clear) begin
      count_q <= '0;
      term_q  <= 1'b0;
    end else if (bus.load) begin
      count_q <= load_clamped;
      term_q  <= 1'b0;
    end else if (bus.en) begin
      if (bus.dir) begin
        if (count_q >= bus.max_in) begin
          count_q <= SATURATE ? bus.max_in : '0;
          term_q  <= 1'b1;
        end else begin
          count_q <= count_q + 1'b1;
          term_q  <= 1'b0;
        end
      end else begin
        // A count stranded above a lowered max_in re-enters at max_in without a limit event.
        if (count_q > bus.max_in) begin
          count_q <= bus.max_in;
          term_q  <= 1'b0;
        end else if (count_q == '0) begin
          count_q <= SATURATE ? '0 : bus.max_in;
          term_q  <= 1'b1;
        end else begin
          count_q <= count_q - 1'b1;
          term_q  <= 1'b0;
        end
      end
    end else begin
      term_q <= 1'b0;
    end
  end

  assign bus.count   = count_q;
  assign bus.term    = term_q;
  assign bus.at_max  = (count_q >= bus.max_in);
  assign bus.at_zero = (count_q == '0);
endmodule
